// File: rtl/lcg_sched_pkg.sv
// Shared constants and per-channel generator state for lcg_scheduler.
package lcg_sched_pkg;
  localparam int LCG_W = 64;
  localparam int SHW   = 6;

  // State fields are stored at LCG_W; the scheduler uses the low W bits.
  typedef struct packed {
    logic [LCG_W-1:0] q;
    logic [SHW-1:0]   r;
    logic [LCG_W-1:0] b;
    logic             seeded;
  } ch_cfg_t;
endpackage

// File: rtl/lcg_step.sv
// One multiplier-less LCG step: next = q*(2^r+1) + b, with r=0 treated as r=1.
module lcg_step
  import lcg_sched_pkg::*;
#(
  parameter int W = LCG_W
)(
  input  logic [W-1:0]   q,
  input  logic [SHW-1:0] r,
  input  logic [W-1:0]   b,
  output logic [W-1:0]   next
);
  logic [SHW-1:0] r_eff;

  assign r_eff = (r == '0) ? SHW'(1) : r;
  assign next  = q + (q << r_eff) + b;
endmodule

// File: rtl/lcg_scheduler.sv
// Round-robin time-multiplexing of one lcg_step across NUM_CH channels.
// Define LCG_CNT_EN to add the per-channel sequence index output out_idx.
module lcg_scheduler
  import lcg_sched_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int W      = LCG_W,
  localparam int CHW    = $clog2(NUM_CH)
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [CHW-1:0]    cfg_ch,
  input  logic [W-1:0]      cfg_seed,
  input  logic [SHW-1:0]    cfg_shift,
  input  logic [W-1:0]      cfg_inc,
  input  logic [NUM_CH-1:0] req,
  output logic [NUM_CH-1:0] gnt,
  output logic              out_valid,
  output logic [CHW-1:0]    out_ch,
  output logic [W-1:0]      out_data,
  input  logic              out_ready,
`ifdef LCG_CNT_EN
  output logic [31:0]       out_idx,
`endif
  output logic              busy
);
  ch_cfg_t [NUM_CH-1:0]           ch;
  logic    [CHW-1:0]              rr, gidx;
  logic                           found, slot_free;
  logic    [NUM_CH-1:0]           elig;
  logic    [NUM_CH-1:0][CHW-1:0]  cand;
  logic    [W-1:0]                nxt;

  // A config write to a channel blocks its grant in the same cycle.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign elig[i] = req[i] & ch[i].seeded & ~(cfg_we & (cfg_ch == CHW'(i)));
    assign cand[i] = CHW'((int'(rr) + i) % NUM_CH);
  end

  assign slot_free = ~out_valid | out_ready;
  assign busy      = out_valid | (|elig);

  always_comb begin
    found = 1'b0;
    gidx  = '0;
    gnt   = '0;
    if (slot_free) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (!found && elig[cand[k]]) begin
          found = 1'b1;
          gidx  = cand[k];
        end
      end
    end
    if (found) gnt[gidx] = 1'b1;
  end

  lcg_step #(.W(W)) u_step (
    .q    (ch[gidx].q[W-1:0]),
    .r    (ch[gidx].r),
    .b    (ch[gidx].b[W-1:0]),
    .next (nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (cfg_we && cfg_ch == CHW'(i))
          ch[i] <= '{q: LCG_W'(cfg_seed), r: cfg_shift, b: LCG_W'(cfg_inc), seeded: 1'b1};
        else if (gnt[i])
          ch[i].q <= LCG_W'(nxt);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_data  <= '0;
      rr        <= '0;
    end else if (found) begin
      out_valid <= 1'b1;
      out_ch    <= gidx;
      out_data  <= nxt;
      rr        <= (gidx == CHW'(NUM_CH - 1)) ? '0 : gidx + 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef LCG_CNT_EN
  logic [NUM_CH-1:0][31:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      out_idx <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (cfg_we && cfg_ch == CHW'(i)) cnt[i] <= '0;
        else if (gnt[i])                 cnt[i] <= cnt[i] + 32'd1;
      end
      if (found) out_idx <= cnt[gidx];
    end
  end
`endif
endmodule

// File: tb/tb_lcg_scheduler.sv
// Directed + randomized bench for lcg_scheduler against a cycle-level reference model.
module tb_lcg_scheduler;
  localparam int N = 4;

  logic        clk = 1'b0, rst_n = 1'b0, cfg_we = 1'b0, out_ready = 1'b1;
  logic [1:0]  cfg_ch = '0;
  logic [63:0] cfg_seed = '0, cfg_inc = '0;
  logic [5:0]  cfg_shift = '0;
  logic [3:0]  req = '0;
  logic [3:0]  gnt;
  logic        out_valid, busy;
  logic [1:0]  out_ch;
  logic [63:0] out_data;
`ifdef LCG_CNT_EN
  logic [31:0] out_idx;
`endif

  int checks = 0, failures = 0;

  // reference model state
  logic [63:0] mq [N];
  logic [63:0] mb [N];
  int          mr [N];
  bit          ms [N];
  int unsigned mcnt [N];
  int          mrr, mch;
  bit          mov;
  logic [63:0] mdata;
  int unsigned midx;

  lcg_scheduler #(.NUM_CH(N), .W(64)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_seed(cfg_seed),
    .cfg_shift(cfg_shift), .cfg_inc(cfg_inc), .req(req), .gnt(gnt),
    .out_valid(out_valid), .out_ch(out_ch), .out_data(out_data), .out_ready(out_ready),
`ifdef LCG_CNT_EN
    .out_idx(out_idx),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  function automatic logic [63:0] ref_next(logic [63:0] q, int r, logic [63:0] b);
    int re;
    re = (r == 0) ? 1 : r;
    return q * ((64'd1 << re) + 64'd1) + b;
  endfunction

  function automatic bit eligible(int i);
    return req[i] && ms[i] && !(cfg_we && int'(cfg_ch) == i);
  endfunction

  function automatic int exp_grant();
    if (mov && !out_ready) return -1;
    for (int k = 0; k < N; k++)
      if (eligible((mrr + k) % N)) return (mrr + k) % N;
    return -1;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mq[i] = '0; mb[i] = '0; mr[i] = 0; ms[i] = 0; mcnt[i] = 0;
    end
    mrr = 0; mch = 0; mov = 0; mdata = '0; midx = 0;
  endtask

  // Called right after a falling edge with inputs already driven.
  task automatic cycle();
    int g;
    bit anyel;
    logic [3:0] eg;
    #1;
    g = exp_grant();
    eg = (g >= 0) ? 4'(1 << g) : 4'b0;
    anyel = 0;
    for (int i = 0; i < N; i++) if (eligible(i)) anyel = 1;
    chk("gnt", 64'(gnt), 64'(eg));
    chk("busy", 64'(busy), 64'(mov | anyel));
    @(posedge clk);
    if (cfg_we) begin
      mq[cfg_ch] = cfg_seed; mr[cfg_ch] = int'(cfg_shift); mb[cfg_ch] = cfg_inc;
      ms[cfg_ch] = 1; mcnt[cfg_ch] = 0;
    end
    if (g >= 0) begin
      mq[g] = ref_next(mq[g], mr[g], mb[g]);
      mdata = mq[g]; mch = g; mov = 1; mrr = (g + 1) % N;
      midx = mcnt[g]; mcnt[g]++;
    end else if (mov && out_ready) begin
      mov = 0;
    end
    #1;
    chk("out_valid", 64'(out_valid), 64'(mov));
    chk("out_ch", 64'(out_ch), 64'(mch));
    chk("out_data", out_data, mdata);
`ifdef LCG_CNT_EN
    chk("out_idx", 64'(out_idx), 64'(midx));
`endif
    @(negedge clk);
  endtask

  task automatic seed(int c, logic [63:0] s, int sh, logic [63:0] inc);
    cfg_we = 1'b1; cfg_ch = 2'(c); cfg_seed = s; cfg_shift = 6'(sh); cfg_inc = inc;
    cycle();
    cfg_we = 1'b0;
  endtask

  initial begin
    logic [63:0] e1 [4];
    logic [63:0] hold;
    e1[0] = 64'd4; e1[1] = 64'd13; e1[2] = 64'd40; e1[3] = 64'd121;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", out_data, 64'd0);
    chk("rst_ch", 64'(out_ch), 64'd0);
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;

    // basic sequence on ch0
    seed(0, 64'd1, 1, 64'd1);
    req = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("t1_seq", out_data, e1[k]);
    end
    req = 4'b0000; cycle();

    // unseeded channel waits; config beats same-cycle grant
    req = 4'b0100;
    repeat (3) cycle();
    seed(2, 64'd5, 2, 64'd0);
    cycle();
    chk("t4_first", out_data, 64'd25);
    req = 4'b0000; cycle();

    // all channels round-robin
    seed(1, {$urandom, $urandom}, 3, {$urandom, $urandom});
    seed(3, {$urandom, $urandom}, 0, {$urandom, $urandom});
    req = 4'b1111;
    repeat (16) cycle();

    // backpressure
    out_ready = 1'b0;
    hold = out_data;
    repeat (5) begin
      cycle();
      chk("t3_hold", out_data, hold);
    end
    out_ready = 1'b1;
    repeat (4) cycle();
    req = 4'b0000; cycle();

    // 64-bit wrap
    seed(3, '1, 1, 64'd3);
    req = 4'b1000; cycle();
    chk("t5_wrap", out_data, 64'd0);
    req = 4'b0000; cycle();

    // randomized traffic, backpressure and reconfiguration
    repeat (400) begin
      req = 4'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      cfg_we = ($urandom_range(0, 7) == 0);
      cfg_ch = 2'($urandom);
      cfg_seed = {$urandom, $urandom};
      cfg_shift = 6'($urandom);
      cfg_inc = {$urandom, $urandom};
      cycle();
    end
    cfg_we = 1'b0; out_ready = 1'b1; req = 4'b0000;
    cycle();

    // async reset while out_valid is high
    seed(0, 64'd9, 2, 64'd1);
    req = 4'b0001; cycle();
    chk("t6_pre", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_valid", 64'(out_valid), 64'd0);
    chk("t6_async_data", out_data, 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'b1111;
    repeat (3) cycle();
    req = 4'b0000;
    seed(1, 64'd7, 3, 64'd1);
    req = 4'b0010;
    cycle();
    chk("t6_reseed", out_data, 64'd64);
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lcg_scheduler.md
Name: lcg_scheduler

Overview:
- Time-multiplexes one multiplier-less LCG step among NUM_CH independent generator channels.
- Per-channel state: current value q, shift r (multiplier a = 2^r + 1), increment b.
- Requesters are served round-robin. Each served request returns the next value of its channel through a single-entry valid/ready output register.
- Sits between the MDCLCG datapath and its consumers; replaces one free-running LCG instance per consumer.

Parameters:
- NUM_CH, 4, number of channels/requesters (2..16).
- W, 64, state/output width.
- CHW, $clog2(NUM_CH), channel index width (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- cfg_we  in  1  write seed/shift/increment for cfg_ch
- cfg_ch  in  CHW  channel being configured
- cfg_seed  in  W  initial q
- cfg_shift  in  6  r; multiplier = 2^r + 1
- cfg_inc  in  W  increment b
- req  in  NUM_CH  per-channel request, level-held until granted
- gnt  out  NUM_CH  one-hot, combinational; request accepted this cycle
- out_valid  out  1  output register holds a value
- out_ch  out  CHW  channel of out_data
- out_data  out  W  generated value
- out_ready  in  1  consumer accepts out_data
- busy  out  1  out_valid or any eligible request pending

Behaviour:
- Reset (async assert, sync-released): all q, r, b = 0; seeded[] = 0; rr pointer = 0; out_valid = 0; out_ch = 0; out_data = 0; gnt = 0.
- Step function: next = (q + (q << r) + b) mod 2^W. No carry out. r = 0 is treated as r = 1.
- Eligibility: channel i is eligible when req[i] & seeded[i] & !(cfg_we & cfg_ch == i).
- Config wins over a grant to the same channel in the same cycle. Requests from unseeded channels are never granted; they wait.
- Slot free when !out_valid | out_ready.
- Grant: if the slot is free and any channel is eligible, gnt is one-hot to the first eligible channel at or after rr (wrapping); otherwise gnt = 0.
- On the grant edge:
  - q[i] <= next(q[i]).
  - out_data <= next(q[i]), out_ch <= i, out_valid <= 1.
  - rr <= (i + 1) mod NUM_CH.
- Latency: grant at cycle t gives out_valid at t+1. Throughput is 1 per cycle while out_ready = 1.
- If out_valid & out_ready and there is no grant: out_valid <= 0.
- If out_valid & !out_ready: out_data and out_ch hold stable, gnt = 0, no state changes except config.
- cfg_we: q[cfg_ch] <= cfg_seed, r <= cfg_shift, b <= cfg_inc, seeded <= 1. A value already in the output register is unaffected.
- Reset mid-transfer: output discarded, all channels return to unseeded.
- busy is combinational.

Optional Feature:
- Macro: LCG_CNT_EN.
- Defined: adds output port out_idx [31:0], the per-channel sequence index of out_data.
  - 0 for the first value after a seed; increments per grant; wraps 2^32-1 to 0.
  - Cleared by cfg_we to that channel; reset value 0.
- Undefined: port and counters absent; all other behaviour identical.

Decomposition:
- Package lcg_sched_pkg: W default, shift-width constant (6), channel-config struct {q, r, b, seeded}.
- Sub-module lcg_step (combinational): inputs q, r, b; output next. It holds the shifter and three-operand add so the adder can be swapped independently.
- Round-robin arbiter stays inline in lcg_scheduler.

Test Plan:
1. Seed ch0 = 1, shift = 1, inc = 1; hold req[0] with out_ready = 1.
   - Outputs 4, 13, 40, 121 on consecutive cycles.
   - gnt[0] every cycle; out_ch = 0.
2. Seed all 4 channels; assert req = 4'b1111 continuously.
   - Grants in order 0,1,2,3,0,… and out_ch follows one cycle later.
   - Each channel's sequence is independent of interleaving.
3. Backpressure: out_ready = 0 for 5 cycles with requests pending.
   - out_valid = 1, out_data/out_ch stable, gnt = 0 for all 5 cycles.
   - First cycle out_ready = 1: new grant, next value appears the following cycle with no loss or duplication.
4. Unseeded/config collision:
   - req[2] with ch2 unseeded → never granted.
   - Same-cycle cfg_we ch2 (seed = 5, shift = 2, inc = 0) and req[2] → no grant that cycle.
   - Next cycle grant → output 25.
5. Wrap: seed = 2^64-1, shift = 1, inc = 3.
   - Output = (2^64-1) + (2^65-2) + 3 mod 2^64 = 0.
6. Reset asserted async mid-stream with out_valid = 1.
   - out_valid drops immediately.
   - After release, req ignored until reseed.
   - With LCG_CNT_EN, out_idx restarts at 0.
